// File: rtl/gsensor_spi_responder.sv
// Purpose: 3-wire SPI responder that stands in for the board accelerometer. It serves a 64x8 register file,
//          a DEVID byte and coherent X/Y/Z sample snapshots, and drives the INT2 data-ready line.
// Latency / backpressure: edges act SYNC_STAGES+1 clk after the pad. There is no backpressure; every sample_valid is accepted.
// Ports:   clk/rst (sync, active-high); sample_x/y/z + sample_valid (sample source);
//          spi_csn/spi_sclk/spi_sdi (master pads, CPOL=1 CPHA=1); spi_sdo/spi_sdo_oe (SDIO drive);
//          int2 (data ready); wr_strobe/wr_addr/wr_data (one pulse per completed write byte).
// Option:  define GSENSOR_RESP_MB_EN to honour the MB bit. When enabled, burst addresses auto-increment modulo 64.
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    output logic        int2,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

`ifdef GSENSOR_RESP_MB_EN
    localparam logic MB_EN = 1'b1;
`else
    localparam logic MB_EN = 1'b0;
`endif

    localparam logic [5:0] SNAP_LO = 6'h32;
    localparam logic [5:0] SNAP_HI = 6'h37;
    localparam logic [5:0] INT_EN  = 6'h2E;
    localparam logic [5:0] INT_MAP = 6'h2F;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, sdi_sync_q;
    logic                   csn_d1_q, sclk_d1_q;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             sh_in_q;
    logic [7:0]             sh_out_q;
    logic [5:0]             addr_q;
    logic                   mb_q;
    logic [7:0]             regs_q [64];
    logic [47:0]            stage_q, snap_q;   // {Z, Y, X}, little-endian bytes
    logic                   data_ready_q;
    logic                   sdo_q, sdo_oe_q, wr_strobe_q;
    logic [5:0]             wr_addr_q;
    logic [7:0]             wr_data_q;

    logic       csn_s, sclk_s, sdi_s;
    logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic       cmd_done, wbyte_done, rbyte_done, shift_en;
    logic [7:0] new_byte, rd_byte;
    logic [5:0] addr_adv, ld_addr;
    logic [2:0] snap_idx;

    function automatic logic is_snap(input logic [5:0] a);
        return (a >= SNAP_LO) && (a <= SNAP_HI);
    endfunction

    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = csn_d1_q & ~csn_s;
    assign cs_rise   = ~csn_d1_q & csn_s;
    assign sclk_rise = ~sclk_d1_q & sclk_s;
    assign sclk_fall = sclk_d1_q & ~sclk_s;

    // sdi is synchronized with the same depth as sclk, so it is aligned with the detected rise.
    assign new_byte = {sh_in_q, sdi_s};
    assign addr_adv = (MB_EN && mb_q) ? addr_q + 6'd1 : addr_q;
    // A shift-out load happens either at the end of the command byte or after each read byte.
    assign ld_addr  = cmd_done ? new_byte[5:0] : addr_adv;
    // 0x32..0x37 map to snapshot bytes 0..5. The low three address bits minus 2 give the byte index.
    assign snap_idx = ld_addr[2:0] - 3'd2;

    always_comb begin
        if (ld_addr == 6'h00) begin
            rd_byte = DEVID;
        end else if (is_snap(ld_addr)) begin
            rd_byte = snap_q[{snap_idx, 3'b000} +: 8];
        end else begin
            rd_byte = regs_q[ld_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_done   = 1'b0;
        wbyte_done = 1'b0;
        rbyte_done = 1'b0;
        shift_en   = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;                    // any partial byte is dropped here
        end else if (cs_fall) begin
            state_d = CMD;
        end else begin
            shift_en = sclk_rise && (state_q != IDLE);
            case (state_q)
                CMD: if (sclk_rise && bit_cnt_q == 3'd7) begin
                    cmd_done = 1'b1;
                    state_d  = new_byte[7] ? RDATA : WDATA;
                end
                WDATA: wbyte_done = sclk_rise && (bit_cnt_q == 3'd7);
                RDATA: rbyte_done = sclk_rise && (bit_cnt_q == 3'd7);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_sync_q   <= '1;
            sclk_sync_q  <= '1;
            sdi_sync_q   <= '0;
            csn_d1_q     <= 1'b1;
            sclk_d1_q    <= 1'b1;
            bit_cnt_q    <= '0;
            sh_in_q      <= '0;
            sh_out_q     <= '0;
            addr_q       <= '0;
            mb_q         <= 1'b0;
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
            stage_q      <= '0;
            snap_q       <= '0;
            data_ready_q <= 1'b0;
            sdo_q        <= 1'b1;
            sdo_oe_q     <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            csn_d1_q    <= csn_s;
            sclk_d1_q   <= sclk_s;
            wr_strobe_q <= 1'b0;

            if (sample_valid) stage_q <= {sample_z, sample_y, sample_x};
            // Snapshot only moves at CS fall so a burst read sees one coherent sample.
            if (cs_fall) begin
                snap_q    <= sample_valid ? {sample_z, sample_y, sample_x} : stage_q;
                bit_cnt_q <= '0;
                sdo_oe_q  <= 1'b0;
            end
            if (cs_rise) begin
                sdo_oe_q <= 1'b0;
                sdo_q    <= 1'b1;
            end

            // Set wins over the clear from a completing snapshot read.
            if (sample_valid)                         data_ready_q <= 1'b1;
            else if (rbyte_done && is_snap(addr_q))   data_ready_q <= 1'b0;

            if (shift_en) begin
                sh_in_q   <= new_byte[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (cmd_done) begin
                mb_q     <= new_byte[6];
                addr_q   <= new_byte[5:0];
                sh_out_q <= rd_byte;
            end
            if (wbyte_done) begin
                if (addr_q != 6'h00 && !is_snap(addr_q)) regs_q[addr_q] <= new_byte;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_q;
                wr_data_q   <= new_byte;
                addr_q      <= addr_adv;
            end
            if (rbyte_done) begin
                addr_q   <= addr_adv;
                sh_out_q <= rd_byte;
            end
            if (sclk_fall && state_q == RDATA && !cs_rise && !cs_fall) begin
                sdo_q    <= sh_out_q[7];
                sh_out_q <= {sh_out_q[6:0], 1'b1};
                sdo_oe_q <= 1'b1;
            end
        end
    end

    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = sdo_oe_q;
    assign int2       = data_ready_q & regs_q[INT_EN][7] & regs_q[INT_MAP][7];
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

SPI responder that models the board accelerometer's 3-wire register interface so the existing G-sensor SPI master can be exercised in simulation and hardware loopback without the physical part. It oversamples the master's CS/SCLK/SDIO on the 50 MHz system clock and decodes the command byte. It serves reads and writes against a 64×8 register file and returns X/Y/Z sample words supplied by a stimulus source. It drives an INT2 data-ready line back to the master.

## Interface
- DEVID, 8'hE5, value returned at address 0x00 (read-only)
- SYNC_STAGES, 2, synchronizer depth on spi_csn/spi_sclk/spi_sdi (≥2)
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- sample_x / sample_y / sample_z  in  16 each  new accelerometer sample, two's complement
- sample_valid  in  1  one-cycle strobe loading sample_x/y/z
- spi_csn  in  1  chip select from master, active-low
- spi_sclk  in  1  SPI clock, CPOL=1 CPHA=1
- spi_sdi  in  1  SDIO pad input
- spi_sdo  out  1  SDIO value when driving
- spi_sdo_oe  out  1  SDIO output enable (tri-state at top level)
- int2  out  1  data-ready interrupt, active-high
- wr_strobe  out  1  one-cycle pulse per completed write byte
- wr_addr  out  6  address of the completed write
- wr_data  out  8  data of the completed write

## Operation
- Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector. All logic acts on the detected edges.
- States: IDLE, CMD, WDATA, RDATA.
- CS falling → CMD, bit counter=0. CS rising in any state → IDLE.
- CMD: shift spi_sdi MSB-first on each SCLK rise. After 8 bits: bit7=R/W (1=read), bit6=MB, bits5:0=address. Go to RDATA or WDATA.
- WDATA: shift 8 bits. At the 8th rise, write the register, pulse wr_strobe with wr_addr/wr_data, and advance the address.
  - Writes to 0x00 and 0x32–0x37 are ignored; wr_strobe still pulses.
- RDATA: at the 8th command rise, load the shift-out register from the current address. On each SCLK fall, drive the next bit MSB-first. spi_sdo_oe is asserted from the first fall after the command until CS rises.
  - After each 8 bits, advance the address and reload.
- Address advance: +1 modulo 64 (0x3F→0x00) when MB=1; unchanged when MB=0.
- Read map:
  - 0x00 returns DEVID.
  - 0x32/0x33 return X low/high; 0x34/0x35 return Y low/high; 0x36/0x37 return Z low/high, all from the snapshot.
  - All other addresses return the register file.
- Snapshot: sample_valid updates a staging set and sets data_ready. CS falling copies staging into the snapshot, so a burst read is coherent. If sample_valid and CS fall occur in the same cycle, the snapshot takes the incoming sample.
- data_ready clears when a read byte at 0x32–0x37 completes. If sample_valid coincides with the clear, the set wins.
- int2 = data_ready & reg[0x2E][7] & reg[0x2F][7].
- CS rising mid-byte:
  - A partial write byte is discarded with no wr_strobe.
  - A partial read byte is abandoned.
- Reset (including mid-transaction):
  - State=IDLE; register file, staging and snapshot are zeroed.
  - spi_sdo=1, spi_sdo_oe=0, int2=0, wr_strobe=0, wr_addr=0, wr_data=0.

## Timing
- Edge-detect latency = SYNC_STAGES+1 clk after the pad edge, i.e. 3 clk at default.
- spi_sdo changes ≤3 clk after the SCLK fall. With SCLK at 2 MHz, a half period is 12.5 clk, so data is stable well before the next rise.
- Requirement: SCLK high and low times are each ≥ SYNC_STAGES+4 clk.
- wr_strobe is asserted 1 clk after the detected 8th rise of a data byte, for exactly 1 clk.
- spi_sdo_oe deasserts 1 clk after the detected CS rise.
- int2 rises 1 clk after sample_valid when enabled. It falls 1 clk after the clearing read byte completes.
- No back-pressure: every sample_valid is accepted, and unread samples are overwritten in staging.

## Configuration
- GSENSOR_RESP_MB_EN:
  - Defined: the MB bit is honoured and address auto-increment applies as above.
  - Undefined: the MB bit is ignored and the address never advances. Every byte of a burst reads or writes the command address, and data_ready clears on the first 0x32–0x37 byte.

## Test plan
- Read 0x00 (command 0x80) → sdo_oe high during the data byte; master captures 0xE5.
- Write 0x2E=0x80 and 0x2F=0x80, then pulse sample_valid with X=0x1234 → wr_strobe twice (0x2E/0x80, 0x2F/0x80); int2=1 one clk after the strobe.
- Burst read command 0xF2 (read, MB, 0x32) for 6 bytes → 34 12 Y_lo Y_hi Z_lo Z_hi. int2 falls after the first byte. A sample_valid mid-burst does not alter the bytes returned.
- MB burst write starting at 0x3F with data AA,BB → 0x3F=0xAA, 0x00 ignored (a read of 0x00 still returns 0xE5), wr_addr sequence 0x3F, 0x00.
- Write command, 4 data bits, then CS high → no wr_strobe, register unchanged; the next transaction decodes normally.
- rst asserted mid read burst → the next clk shows sdo_oe=0, int2=0 and state IDLE; a following read of 0x2E returns 0x00.
